// File: rtl/la_packet_pkg.sv
// Shared definitions for the logic-analyzer LVDS packet link: word layout,
// frame markers and the checksum used by both encoder and decoder.
package la_packet_pkg;

  localparam int TYPE_W    = 6;
  localparam int PAYLOAD_W = 48;
  localparam int WORD_W    = 28;

  localparam logic [3:0] MK_HDR  = 4'hA;
  localparam logic [3:0] MK_MID  = 4'h5;
  localparam logic [3:0] MK_TAIL = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_W0,
    ST_W1,
    ST_W2
  } enc_state_t;

  typedef struct packed {
    logic [TYPE_W-1:0]    ptype;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

  // Byte-wise sum of the payload plus the zero-extended type, modulo 256.
  function automatic logic [7:0] packet_checksum(input logic [TYPE_W-1:0]    ptype,
                                                 input logic [PAYLOAD_W-1:0] pay);
    logic [7:0] sum;
    sum = {2'b00, ptype};
    for (int i = 0; i < PAYLOAD_W / 8; i++) begin
      sum = sum + pay[i*8 +: 8];
    end
    return sum;
  endfunction

endpackage

// File: rtl/packet_encoder.sv
// Transmit framer: one buffered packet is serialized into three marked 28-bit
// words, separated from the next frame by at least MIN_IDLE (0..15) idle words.
module packet_encoder
  import la_packet_pkg::*;
#(
  parameter int unsigned       MIN_IDLE  = 1,
  parameter logic [WORD_W-1:0] IDLE_WORD = 28'h0000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TYPE_W-1:0]    packet_type,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic                 valid,
  output logic                 ready,
  output logic [WORD_W-1:0]    txd,
  output logic                 busy,
  output logic [15:0]          tx_count
);

  localparam logic [3:0] GAP_MAX      = 4'(MIN_IDLE);
  localparam bit         BACK_TO_BACK = (MIN_IDLE == 0);

  enc_state_t        state_reg, state_next;
  logic [WORD_W-1:0] txd_reg, txd_next;
  logic [3:0]        gap_reg, gap_next;
  logic              buf_full_reg, buf_full_next;
  packet_t           buf_reg, buf_next;
  packet_t           shift_reg, shift_next;
  logic [15:0]       count_reg, count_next;

  logic              gap_ok;
  logic              take;
  logic              load;
  logic [WORD_W-1:0] w0, w1, w2;

  // W0 is built straight from the buffer because it is loaded on the same
  // edge that the buffer contents move into the shift register.
  assign w0 = {MK_HDR, buf_reg.ptype, buf_reg.payload[47:30]};
  assign w1 = {MK_MID, shift_reg.payload[29:6]};
  assign w2 = {MK_TAIL, shift_reg.payload[5:0], 10'b0,
               packet_checksum(shift_reg.ptype, shift_reg.payload)};

  generate
    if (MIN_IDLE == 0) begin : g_no_gap
      assign gap_ok = 1'b1;
    end else begin : g_gap
      assign gap_ok = (gap_reg >= GAP_MAX);
    end
  endgenerate

  assign load = valid && !buf_full_reg;

  always_comb begin
    state_next    = state_reg;
    txd_next      = txd_reg;
    gap_next      = gap_reg;
    buf_full_next = buf_full_reg;
    buf_next      = buf_reg;
    shift_next    = shift_reg;
    count_next    = count_reg;
    take          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        txd_next = IDLE_WORD;
        if (!gap_ok) begin
          gap_next = gap_reg + 4'd1;
        end
        if (buf_full_reg && gap_ok) begin
          take = 1'b1;
        end
      end
      ST_W0: begin
        txd_next   = w1;
        state_next = ST_W1;
      end
      ST_W1: begin
        txd_next   = w2;
        state_next = ST_W2;
        count_next = count_reg + 16'd1;
      end
      ST_W2: begin
        if (BACK_TO_BACK && buf_full_reg) begin
          take = 1'b1;
        end else begin
          txd_next   = IDLE_WORD;
          gap_next   = 4'd1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        txd_next   = IDLE_WORD;
        state_next = ST_IDLE;
      end
    endcase

    // take needs a full buffer and load an empty one, so they never collide.
    if (take) begin
      txd_next      = w0;
      shift_next    = buf_reg;
      buf_full_next = 1'b0;
      state_next    = ST_W0;
    end
    if (load) begin
      buf_next      = {packet_type, payload};
      buf_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      txd_reg      <= IDLE_WORD;
      gap_reg      <= GAP_MAX;
      buf_full_reg <= 1'b0;
      buf_reg      <= '0;
      shift_reg    <= '0;
      count_reg    <= 16'd0;
    end else begin
      state_reg    <= state_next;
      txd_reg      <= txd_next;
      gap_reg      <= gap_next;
      buf_full_reg <= buf_full_next;
      buf_reg      <= buf_next;
      shift_reg    <= shift_next;
      count_reg    <= count_next;
    end
  end

  assign ready    = !buf_full_reg;
  assign busy     = (state_reg != ST_IDLE) || buf_full_reg;
  assign txd      = txd_reg;
  assign tx_count = count_reg;

endmodule

// File: tb/tb_packet_encoder.sv
// Bench for packet_encoder: three instances (MIN_IDLE = 0, 1, 2) checked every
// cycle against a timeline model of frames, plus table vectors and corner cases.
module tb_packet_encoder;

  localparam logic [27:0] IDLE = 28'h0C0FFEE;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        vin [3];
  logic [5:0]  tin [3];
  logic [47:0] pin [3];
  logic        rdy [3];
  logic [27:0] txd [3];
  logic        bsy [3];
  logic [15:0] cnt [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      packet_encoder #(.MIN_IDLE(gi), .IDLE_WORD(IDLE)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .packet_type (tin[gi]),
        .payload     (pin[gi]),
        .valid       (vin[gi]),
        .ready       (rdy[gi]),
        .txd         (txd[gi]),
        .busy        (bsy[gi]),
        .tx_count    (cnt[gi])
      );
    end
  endgenerate

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a pending packet, the earliest cycle a frame may start, and the
  // start cycle plus words of the most recent frame.
  logic        m_full [3];
  logic [5:0]  m_bt   [3];
  logic [47:0] m_bp   [3];
  int          m_next [3];
  int          m_fs   [3];
  logic [27:0] m_w    [3][3];
  logic [15:0] m_cnt  [3];
  logic [27:0] m_txd  [3];
  logic        m_busy [3];
  logic        hs     [3];

  typedef struct {
    logic [5:0]       t;
    logic [47:0]      p;
    logic [2:0][27:0] w;
  } vec_t;

  vec_t tbl [4];

  function automatic logic [27:0] frame_word(input logic [5:0] t, input logic [47:0] p, input int i);
    int          s;
    logic [27:0] r;
    s = int'(t);
    for (int b = 0; b < 6; b++) s += int'((p >> (8 * b)) & 48'hFF);
    if (i == 0)      r = (28'hA << 24) | (28'(t) << 18) | 28'(p >> 30);
    else if (i == 1) r = (28'h5 << 24) | 28'((p >> 6) & 48'hFFFFFF);
    else             r = (28'h3 << 24) | (28'(p & 48'h3F) << 18) | 28'(s % 256);
    return r;
  endfunction

  task automatic check(input string nm, input int d, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, d, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      check("txd", d, 48'(txd[d]), 48'(m_txd[d]));
      check("ready", d, 48'(rdy[d]), 48'(!m_full[d]));
      check("busy", d, 48'(bsy[d]), 48'(m_busy[d]));
      check("tx_count", d, 48'(cnt[d]), 48'(m_cnt[d]));
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_full[d] = 1'b0;
      m_next[d] = 0;
      m_fs[d]   = -1000000;
      m_cnt[d]  = 16'd0;
      m_txd[d]  = IDLE;
      m_busy[d] = 1'b0;
      hs[d]     = 1'b0;
    end
  endtask

  task automatic model_edge();
    int idx;
    logic take;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      hs[d] = vin[d] && !m_full[d];
      take  = m_full[d] && (cyc >= m_next[d]);
      if (take) begin
        m_fs[d] = cyc;
        for (int i = 0; i < 3; i++) m_w[d][i] = frame_word(m_bt[d], m_bp[d], i);
        m_next[d] = cyc + 3 + d;
        m_full[d] = 1'b0;
      end
      if (hs[d]) begin
        m_full[d] = 1'b1;
        m_bt[d]   = tin[d];
        m_bp[d]   = pin[d];
        $display("dut%0d cyc=%0d accept type=%h payload=%h", d, cyc, tin[d], pin[d]);
      end
      idx = cyc - m_fs[d];
      m_txd[d]  = (idx >= 0 && idx <= 2) ? m_w[d][idx] : IDLE;
      if (idx == 2) m_cnt[d] = m_cnt[d] + 16'd1;
      m_busy[d] = (idx >= 0 && idx <= 2) || m_full[d];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int sent;
    int run;
    int max_run;

    tbl[0] = '{t: 6'h01, p: 48'h0123_4567_89AB, w: {28'h3AC0005, 28'h5159E26, 28'hA04048D}};
    tbl[1] = '{t: 6'h3F, p: 48'hFFFF_FFFF_FFFF, w: {28'h3FC0039, 28'h5FFFFFF, 28'hAFFFFFF}};
    tbl[2] = '{t: 6'h00, p: 48'h0000_0000_0000, w: {28'h3000000, 28'h5000000, 28'hA000000}};
    tbl[3] = '{t: 6'h2A, p: 48'h8000_0000_0001, w: {28'h30400AB, 28'h5000000, 28'hAAA0000}};

    for (int d = 0; d < 3; d++) begin
      vin[d] = 1'b0;
      tin[d] = '0;
      pin[d] = '0;
    end
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Table vectors on the MIN_IDLE = 1 instance: W0/W1/W2 follow the handshake.
    for (int i = 0; i < 4; i++) begin
      vin[1] = 1'b1;
      tin[1] = tbl[i].t;
      pin[1] = tbl[i].p;
      cycle();
      vin[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        cycle();
        check("tbl_word", 1, 48'(txd[1]), 48'(tbl[i].w[k]));
      end
      cycle();
      cycle();
    end
    check("tbl_count", 1, 48'(cnt[1]), 48'd4);

    // Four packets with valid held high on MIN_IDLE = 2.
    sent   = 0;
    vin[2] = 1'b1;
    tin[2] = 6'($urandom);
    pin[2] = {16'($urandom), 32'($urandom)};
    for (int c = 0; c < 80 && sent < 4; c++) begin
      cycle();
      if (hs[2]) begin
        sent++;
        tin[2] = 6'($urandom);
        pin[2] = {16'($urandom), 32'($urandom)};
      end
    end
    vin[2] = 1'b0;
    repeat (12) cycle();
    check("b2b_count", 2, 48'(cnt[2]), 48'd4);

    // MIN_IDLE = 0: three queued packets give nine contiguous frame words.
    sent    = 0;
    run     = 0;
    max_run = 0;
    vin[0]  = 1'b1;
    tin[0]  = 6'($urandom);
    pin[0]  = {16'($urandom), 32'($urandom)};
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (hs[0]) begin
        sent++;
        tin[0] = 6'($urandom);
        pin[0] = {16'($urandom), 32'($urandom)};
        if (sent == 3) vin[0] = 1'b0;
      end
      run     = (txd[0] != IDLE) ? run + 1 : 0;
      max_run = (run > max_run) ? run : max_run;
    end
    vin[0] = 1'b0;
    check("b2b0_run", 0, 48'(max_run), 48'd9);
    check("b2b0_count", 0, 48'(cnt[0]), 48'd3);

    // Backpressure: data keeps changing while the buffer is full.
    vin[1] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tin[1] = 6'($urandom);
      pin[1] = {16'($urandom), 32'($urandom)};
      cycle();
    end
    vin[1] = 1'b0;
    repeat (8) cycle();

    // Reset while the MIN_IDLE = 1 instance is driving W1.
    vin[1] = 1'b1;
    tin[1] = 6'h15;
    pin[1] = 48'hDEAD_BEEF_CAFE;
    cycle();
    vin[1] = 1'b0;
    cycle();
    cycle();
    check("pre_rst_w1", 1, 48'(txd[1]), 48'(frame_word(6'h15, 48'hDEAD_BEEF_CAFE, 1)));
    #2 rst_n = 1'b0;
    #1;
    check("rst_txd", 1, 48'(txd[1]), 48'(IDLE));
    check("rst_ready", 1, 48'(rdy[1]), 48'd1);
    check("rst_busy", 1, 48'(bsy[1]), 48'd0);
    check("rst_count", 1, 48'(cnt[1]), 48'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    repeat (4) cycle();

    // Randomized traffic on all three instances.
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 3; d++) begin
        vin[d] = ($urandom_range(9) < 7);
        tin[d] = 6'($urandom);
        pin[d] = {16'($urandom), 32'($urandom)};
      end
      cycle();
    end
    for (int d = 0; d < 3; d++) vin[d] = 1'b0;
    repeat (15) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
